// File: rtl/hld_pkg.sv
// Shared types and constants for the hold-release controller.
package hld_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_EVAL,
      S_HOLD,
      S_RELEASE,
      S_TRACK
   } state_t;

   typedef enum logic {
      RET_SEARCH,
      RET_TRACK
   } ret_t;

   // Mid-scale delay-line code, used as the SAR starting point.
   function automatic int mid_code(input int w);
      return 1 << (w - 1);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous flags; clears to 0 on reset.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/hld_release_ctrl.sv
// SAR search and tracking loop for the delay-line code; freezes on hold and
// pulses Sel to clear the hold flops, reporting lock and release failure.
module hld_release_ctrl
   import hld_pkg::*;
#(
   parameter int CODE_W    = 6,
   parameter int SETTLE    = 4,
   parameter int HOLD_WAIT = 4,
   parameter int SEL_W     = 2,
   parameter int MAX_RETRY = 3,
   parameter int LOCK_CNT  = 8
) (
   input  logic              clk4,
   input  logic              rst_n,
   input  logic              start,
   input  logic              HLD1,
   input  logic              HLD2,
   input  logic              UP,
   input  logic              DN,
   output logic              Sel,
   output logic [CODE_W-1:0] code,
   output logic              busy,
   output logic              lock,
   output logic              err
);

   localparam int CNT_MAX = (SETTLE > HOLD_WAIT) ? ((SETTLE > SEL_W) ? SETTLE : SEL_W)
                                                 : ((HOLD_WAIT > SEL_W) ? HOLD_WAIT : SEL_W);
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam int BI_W  = $clog2(CODE_W);
   localparam int LC_W  = $clog2(LOCK_CNT + 1);
   localparam int RT_W  = $clog2(MAX_RETRY + 1);
   localparam logic [CODE_W-1:0] MID      = CODE_W'(mid_code(CODE_W));
   localparam logic [CODE_W-1:0] CODE_MAX = '1;
   localparam logic [BI_W-1:0]   TOP      = BI_W'(CODE_W - 1);

   logic [3:0] raw, syn;
   logic       hold_any, up_s, dn_s;

   assign raw = {DN, UP, HLD2, HLD1};

   for (genvar i = 0; i < 4; i++) begin : g_sync
      sync2 u_sync (.clk(clk4), .rst_n(rst_n), .d(raw[i]), .q(syn[i]));
   end

   assign hold_any = syn[0] | syn[1];
   assign up_s     = syn[2];
   assign dn_s     = syn[3];

   state_t            state, state_n;
   ret_t              ret, ret_n;
   logic [CODE_W-1:0] code_n;
   logic [BI_W-1:0]   bit_idx, bit_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [LC_W-1:0]   lock_cnt, lcnt_n;
   logic [RT_W-1:0]   retry, retry_n;
   logic              lock_n, sel_n, err_n;

   always_ff @(posedge clk4 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ret      <= RET_SEARCH;
         code     <= MID;
         bit_idx  <= TOP;
         cnt      <= '0;
         lock_cnt <= '0;
         retry    <= '0;
         lock     <= 1'b0;
         Sel      <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         ret      <= ret_n;
         code     <= code_n;
         bit_idx  <= bit_n;
         cnt      <= cnt_n;
         lock_cnt <= lcnt_n;
         retry    <= retry_n;
         lock     <= lock_n;
         Sel      <= sel_n;
         err      <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      ret_n   = ret;
      code_n  = code;
      bit_n   = bit_idx;
      cnt_n   = cnt;
      lcnt_n  = lock_cnt;
      retry_n = retry;
      lock_n  = lock;
      sel_n   = 1'b0;
      err_n   = err;
      if (!start) begin
         state_n = S_IDLE;
         ret_n   = RET_SEARCH;
         code_n  = MID;
         bit_n   = TOP;
         cnt_n   = '0;
         lcnt_n  = '0;
         retry_n = '0;
         lock_n  = 1'b0;
         err_n   = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               code_n = MID;
               bit_n  = TOP;
               cnt_n  = '0;
               lock_n = 1'b0;
               if (!err) begin
                  state_n = S_SETTLE;
                  ret_n   = RET_SEARCH;
               end
            end
            S_SETTLE: begin
               if (hold_any) begin
                  state_n = S_HOLD;
                  cnt_n   = '0;
                  lock_n  = 1'b0;
                  retry_n = '0;
               end else if (cnt == CNT_W'(SETTLE - 1)) begin
                  cnt_n   = '0;
                  state_n = (ret == RET_SEARCH) ? S_EVAL : S_TRACK;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            S_EVAL: begin
               // hold wins: the evaluation is dropped and redone after release
               if (hold_any) begin
                  state_n = S_HOLD;
                  cnt_n   = '0;
                  lock_n  = 1'b0;
                  retry_n = '0;
               end else begin
                  if (dn_s && !up_s) code_n[bit_idx] = 1'b0;
                  if (bit_idx != '0) begin
                     code_n[bit_idx - BI_W'(1)] = 1'b1;
                     bit_n = bit_idx - BI_W'(1);
                  end else begin
                     ret_n  = RET_TRACK;
                     lcnt_n = '0;
                  end
                  state_n = S_SETTLE;
                  cnt_n   = '0;
               end
            end
            S_TRACK: begin
               if (hold_any) begin
                  state_n = S_HOLD;
                  cnt_n   = '0;
                  lock_n  = 1'b0;
                  retry_n = '0;
               end else if (cnt == CNT_W'(SETTLE - 1)) begin
                  cnt_n = '0;
                  if (up_s && !dn_s) begin
                     lcnt_n = '0;
                     if (code == CODE_MAX) lock_n = 1'b0;
                     else                  code_n = code + CODE_W'(1);
                  end else if (dn_s && !up_s) begin
                     lcnt_n = '0;
                     if (code == '0) lock_n = 1'b0;
                     else            code_n = code - CODE_W'(1);
                  end else begin
                     if (lock_cnt != LC_W'(LOCK_CNT)) lcnt_n = lock_cnt + LC_W'(1);
                     if (lock_cnt >= LC_W'(LOCK_CNT - 1)) lock_n = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (cnt == CNT_W'(HOLD_WAIT - 1)) begin
                  cnt_n = '0;
                  if (!hold_any) begin
                     state_n = S_SETTLE;
                  end else if (retry == RT_W'(MAX_RETRY)) begin
                     err_n   = 1'b1;
                     state_n = S_IDLE;
                  end else begin
                     state_n = S_RELEASE;
                     sel_n   = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            S_RELEASE: begin
               sel_n = 1'b1;
               if (cnt == CNT_W'(SEL_W - 1)) begin
                  sel_n   = 1'b0;
                  state_n = S_HOLD;
                  cnt_n   = '0;
                  retry_n = retry + RT_W'(1);
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule
